// File: rtl/serial_deser_pkg.sv
// Shared types and constants for the serial deserializer.
// The PARITY state is reachable only when SERIAL_DESER_PARITY_EN is defined.
package serial_deser_pkg;

    localparam int DEFAULT_DATA_W = 8;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

endpackage

// File: rtl/deser_out_holder.sv
// One-entry output register for the deserializer.
// Rules: load on completion, release on accept, drop with a sticky overrun.
module deser_out_holder
    import serial_deser_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              done,
    input  logic [DATA_W-1:0] done_word,
    input  logic              done_perr,
    input  logic              q_ready,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              parity_err,
    output logic              overrun
);

    logic [DATA_W-1:0] q_word_q, q_word_d;
    logic              q_valid_q, q_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              overrun_q, overrun_d;

    always_comb begin
        q_word_d     = q_word_q;
        q_valid_d    = q_valid_q;
        parity_err_d = parity_err_q;
        overrun_d    = overrun_q;
        if (ovr_clr) begin
            overrun_d = 1'b0;
        end
        // A same-edge drop overrides ovr_clr so no lost word goes unreported.
        if (done) begin
            if (!q_valid_q || q_ready) begin
                q_word_d     = done_word;
                parity_err_d = done_perr;
                q_valid_d    = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (q_valid_q && q_ready) begin
            q_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_word_q     <= '0;
            q_valid_q    <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            q_word_q     <= q_word_d;
            q_valid_q    <= q_valid_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign q          = q_word_q;
    assign q_valid    = q_valid_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: rtl/serial_deserializer_8.sv
// Serial-to-parallel receiver: frame FSM, bit counter and shift register.
// Define SERIAL_DESER_PARITY_EN to add a trailing even-parity bit per frame.
module serial_deserializer_8
    import serial_deser_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              sin,
    input  logic              sin_en,
    input  logic              sof,
    input  logic              dir,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    input  logic              q_ready,
    output logic              busy,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic              parity_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic              dir_q, dir_d;
    logic              last_bit;
    logic              done;
    logic [DATA_W-1:0] done_word;
    logic              done_perr;

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] s,
                                                   input logic d, input logic b);
        return (d == DIR_LEFT) ? {s[DATA_W-2:0], b} : {b, s[DATA_W-1:1]};
    endfunction

    assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // sof always restarts a frame, whatever state we are in.
    always_comb begin
        state_d = state_q;
        if (sin_en) begin
            if (sof) begin
                state_d = SHIFT;
            end else begin
                case (state_q)
`ifdef SERIAL_DESER_PARITY_EN
                    SHIFT:   if (last_bit) state_d = PARITY;
                    PARITY:  state_d = IDLE;
`else
                    SHIFT:   if (last_bit) state_d = IDLE;
`endif
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        done      = 1'b0;
        done_word = shift_in(sreg_q, dir_q, sin);
        done_perr = 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
        // The parity bit is checked but never shifted into the word.
        if (sin_en && !sof && (state_q == PARITY)) begin
            done      = 1'b1;
            done_word = sreg_q;
            done_perr = (^sreg_q) ^ sin;
        end
`else
        if (sin_en && !sof && (state_q == SHIFT) && last_bit) begin
            done = 1'b1;
        end
`endif
    end

    always_comb begin
        cnt_d  = cnt_q;
        sreg_d = sreg_q;
        dir_d  = dir_q;
        if (sin_en) begin
            if (sof) begin
                sreg_d = shift_in(sreg_q, dir, sin);
                dir_d  = dir;
                cnt_d  = CNT_W'(1);
            end else if (state_q == SHIFT) begin
                sreg_d = shift_in(sreg_q, dir_q, sin);
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= '0;
            dir_q <= DIR_RIGHT;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    // Stale contents are harmless: a full frame overwrites every bit.
    always_ff @(posedge clk) begin
        sreg_q <= sreg_d;
    end

    deser_out_holder #(.DATA_W(DATA_W)) u_holder (
        .clk        (clk),
        .clr        (clr),
        .done       (done),
        .done_word  (done_word),
        .done_perr  (done_perr),
        .q_ready    (q_ready),
        .ovr_clr    (ovr_clr),
        .q          (q),
        .q_valid    (q_valid),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_serial_deserializer_8.sv
// Scoreboard bench for serial_deserializer_8 (handles SERIAL_DESER_PARITY_EN too).
module tb_serial_deserializer_8;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         clr, sin, sin_en, sof, dir, q_ready, ovr_clr;
    logic [W-1:0] q;
    logic         q_valid, busy, overrun, parity_err;

    always #5 clk = ~clk;

    serial_deserializer_8 #(.DATA_W(W)) dut (
        .clk        (clk),
        .clr        (clr),
        .sin        (sin),
        .sin_en     (sin_en),
        .sof        (sof),
        .dir        (dir),
        .q          (q),
        .q_valid    (q_valid),
        .q_ready    (q_ready),
        .busy       (busy),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr),
        .parity_err (parity_err)
    );

    int         n_chk = 0;
    int         n_fail = 0;
    logic [W:0] sb[$];
    logic [W:0] mon_e;
    bit         mdl_valid = 1'b0;
    bit         mdl_ovr = 1'b0;
    bit         run_chk = 1'b0;
    int         gap_pct = 0;
    int         oc_pct = 0;
    int         rdy_mode = 1;
    int         rdy_last_mode = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic pick(input int mode);
        if (mode == 2) return rbit();
        return (mode != 0);
    endfunction

    function automatic logic roll(input int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    // Drive one clock of inputs, then advance the output model by the spec rules.
    task automatic cyc(input logic b, input logic en, input logic s, input logic d,
                       input logic rdy, input logic oc, input logic fin, input logic [W:0] item);
        sin = b; sin_en = en; sof = s; dir = d; q_ready = rdy; ovr_clr = oc;
        @(posedge clk);
        if (oc) mdl_ovr = 1'b0;
        if (fin) begin
            if (!mdl_valid || rdy) begin
                sb.push_back(item);
                mdl_valid = 1'b1;
            end else begin
                mdl_ovr = 1'b1;
            end
        end else if (mdl_valid && rdy) begin
            mdl_valid = 1'b0;
        end
        #1;
    endtask

    task automatic gap();
        cyc(rbit(), 1'b0, rbit(), rbit(), pick(rdy_mode), roll(oc_pct), 1'b0, '0);
    endtask

    task automatic send_bit(input logic b, input logic s, input logic d,
                            input logic fin, input logic [W:0] item);
        logic rdy;
        while (roll(gap_pct)) gap();
        rdy = (fin && rdy_last_mode >= 0) ? pick(rdy_last_mode) : pick(rdy_mode);
        cyc(b, 1'b1, s, d, rdy, roll(oc_pct), fin, item);
    endtask

    task automatic send_frame(input logic [W-1:0] w, input logic d, input logic pflip);
        logic [W:0] item;
        logic       b;
        logic       last;
`ifdef SERIAL_DESER_PARITY_EN
        item = {pflip, w};
`else
        item = {1'b0, w};
`endif
        for (int i = 0; i < W; i++) begin
            b = d ? w[W-1-i] : w[i];
`ifdef SERIAL_DESER_PARITY_EN
            last = 1'b0;
`else
            last = (i == W - 1);
`endif
            send_bit(b, (i == 0), (i == 0) ? d : rbit(), last, item);
        end
`ifdef SERIAL_DESER_PARITY_EN
        send_bit((^w) ^ pflip, 1'b0, rbit(), 1'b1, item);
`endif
    endtask

    task automatic send_partial(input int n, input logic d);
        for (int i = 0; i < n; i++) begin
            send_bit(rbit(), (i == 0), (i == 0) ? d : rbit(), 1'b0, '0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_q"}, 32'(q), 32'h0);
        chk({tag, "_q_valid"}, 32'(q_valid), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_overrun"}, 32'(overrun), 32'h0);
        chk({tag, "_parity_err"}, 32'(parity_err), 32'h0);
    endtask

    // Monitor: status every cycle, and a scoreboard pop on each handshake.
    always @(negedge clk) begin
        if (run_chk) begin
            chk("mon_q_valid", 32'(q_valid), 32'(mdl_valid));
            chk("mon_overrun", 32'(overrun), 32'(mdl_ovr));
            if (q_valid === 1'b1 && q_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got word %0h, required no word", q);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_word", 32'(q), 32'(mon_e[W-1:0]));
                    chk("sb_parity_err", 32'(parity_err), 32'(mon_e[W]));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        clr = 1'b0; sin = 1'b0; sin_en = 1'b0; sof = 1'b0; dir = 1'b0;
        q_ready = 1'b0; ovr_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        clr = 1'b1;
        run_chk = 1'b1;

        // Reset in the middle of a frame, then a clean frame.
        rdy_mode = 1;
        send_partial(3, 1'b0);
        chk("midframe_busy", 32'(busy), 32'h1);
        run_chk = 1'b0;
        clr = 1'b0;
        sin_en = 1'b0;
        sb.delete();
        mdl_valid = 1'b0;
        mdl_ovr = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(posedge clk);
        #1;
        clr = 1'b1;
        run_chk = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b0);
        chk("after_reset_q", 32'(q), 32'h5A);
        idle(2);

        // LSB-first 1,0,1,1,0,0,1,0
        send_frame(8'h4D, 1'b0, 1'b0);
        chk("lsb_first_q", 32'(q), 32'h4D);
        chk("lsb_first_valid", 32'(q_valid), 32'h1);
        idle(2);

        // MSB-first 1,0,1,0,0,1,0,1
        send_frame(8'hA5, 1'b1, 1'b0);
        chk("msb_first_q", 32'(q), 32'hA5);
        idle(2);

        // Back-to-back with no consumer: second word is dropped.
        rdy_mode = 0;
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        chk("ovr_q_kept", 32'(q), 32'h11);
        chk("ovr_flag", 32'(overrun), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        chk("ovr_cleared", 32'(overrun), 32'h0);
        rdy_last_mode = 1;
        send_frame(8'h33, 1'b0, 1'b0);
        chk("accept_load_q", 32'(q), 32'h33);
        chk("accept_load_valid", 32'(q_valid), 32'h1);
        chk("accept_load_ovr", 32'(overrun), 32'h0);
        rdy_last_mode = -1;
        rdy_mode = 1;
        idle(2);

        // Abort after 5 bits, then a gapped frame.
        gap_pct = 40;
        send_partial(5, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b0);
        chk("abort_q", 32'(q), 32'hF0);
        idle(2);
        chk("abort_one_word", 32'(sb.size()), 32'h0);
        gap_pct = 0;

`ifdef SERIAL_DESER_PARITY_EN
        send_frame(8'h07, 1'b0, 1'b0);
        chk("parity_good", 32'(parity_err), 32'h0);
        idle(2);
        send_frame(8'h07, 1'b1, 1'b1);
        chk("parity_bad", 32'(parity_err), 32'h1);
        idle(2);
`endif

        // Randomized traffic: gaps, aborts, back-pressure, overrun clears.
        gap_pct = 25;
        oc_pct = 10;
        rdy_mode = 2;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 4) == 0) send_partial(int'($urandom_range(1, W - 1)), rbit());
            send_frame(W'($urandom), rbit(), rbit());
        end
        rdy_mode = 1;
        oc_pct = 0;
        gap_pct = 0;
        idle(3);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_deserializer_8.md
# serial_deserializer_8

Receive-side companion to the universal shift register: it collects a serial bitstream, one bit per qualified clock edge, into a parallel word and presents it on a valid/ready output port. It has a bit counter, a small frame state machine and a one-entry output holding register with overrun detection. It sits between a serial link input and any parallel consumer in the datapath.

## Interface
- DATA_W, default 8: word width; counter width is clog2(DATA_W+1).
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous, active-low reset.
- sin  in  1  serial data bit.
- sin_en  in  1  sin is sampled on this edge.
- sof  in  1  start of frame; qualified by sin_en; the bit sampled with it is frame bit 0.
- dir  in  1  0: shift right (bit enters MSB, LSB-first frame); 1: shift left (bit enters LSB, MSB-first frame); sampled with sof, held for the whole frame.
- q  out  DATA_W  assembled word.
- q_valid  out  1  q holds an unconsumed word.
- q_ready  in  1  consumer accepts q on an edge where q_valid=1.
- busy  out  1  frame in progress.
- overrun  out  1  sticky; a completed word was dropped.
- ovr_clr  in  1  synchronous clear of overrun.
- parity_err  out  1  parity status of q; valid with q_valid.

## Operation
- States: IDLE, SHIFT, and PARITY (PARITY only with the macro).
- IDLE: sin_en without sof is ignored. sin_en&sof loads bit 0 into the shift register, latches dir, sets cnt=1 and goes to SHIFT.
- SHIFT: each sin_en shifts in one bit and increments cnt. If cnt reaches DATA_W, the word is complete; the next state is IDLE, or PARITY when the macro is enabled.
- sin_en&sof in SHIFT or PARITY aborts the partial frame with no output and no flag. That bit is taken as bit 0 of a new frame.
- Completion with q_valid=0, or with q_valid=1 and q_ready=1 on the same edge: load q from the completed word, q_valid=1.
- Completion with q_valid=1 and q_ready=0: drop the word, keep the old q, set overrun.
- q_valid&q_ready with no completion on that edge: q_valid=0, and q keeps its last value.
- ovr_clr clears overrun. If ovr_clr and a new overrun occur on the same edge, the set wins.
- busy=1 in SHIFT and PARITY.
- Shift register contents during a frame are internal; q changes only on load.

## Timing
- Reset values: q=0, q_valid=0, busy=0, overrun=0, parity_err=0, cnt=0, state IDLE.
- Reset asserted mid-frame discards the frame immediately.
- The last bit sampled at edge N gives q and q_valid=1 after edge N. Latency is 1 edge.
- Throughput is one bit per sin_en. A new frame may start on the edge right after completion.
- Gaps (sin_en=0) in a frame are allowed indefinitely. The counter holds through them.
- q_ready is ignored while q_valid=0.

## Configuration
- SERIAL_DESER_PARITY_EN defined:
  - Each frame carries one extra bit after the DATA_W data bits, handled in PARITY. That bit is even parity over data plus parity bit.
  - On the parity edge the word completes. parity_err is loaded together with q: 1 if the XOR of the data bits and the parity bit is 1.
  - The parity bit never enters q.
- Not defined: frames are DATA_W bits, the PARITY state does not exist, and parity_err is tied to 0.

## Structure
- Package serial_deser_pkg holds the state enum (IDLE, SHIFT, PARITY), the DIR_RIGHT=0 and DIR_LEFT=1 constants, and the default DATA_W.
- Sub-module deser_out_holder contains q, q_valid, parity_err and overrun with their load/accept/drop rules. The top level holds the FSM, counter and shift register.

## Test plan
- Reset mid-frame: release clr after 3 bits, then send a full frame. Required: all outputs 0 after reset; only the second frame appears.
- dir=0, LSB-first bits 1,0,1,1,0,0,1,0 with q_ready=1. Required: q=8'h4D, with q_valid on the edge after bit 7.
- dir=1, MSB-first bits 1,0,1,0,0,1,0,1. Required: q=8'hA5.
- Back-to-back frames:
  - q_ready=0: frames 8'h11 then 8'h22. Required: q stays 8'h11 and overrun=1.
  - ovr_clr, then q_ready=1 on the completion edge of a frame 8'h33. Required: q=8'h33, q_valid stays 1, overrun=0.
- sof after 5 bits, then 8 bits of 8'hF0 with gaps. Required: exactly one word 8'hF0.
- With the macro: data 8'h07 plus parity bit 1 gives parity_err=0; parity bit 0 gives parity_err=1.
